// File: rtl/opl3_pkg.sv
// Shared OPL3 audio-path types and board-level constants.
// Covers the serial audio transmitter's mode and state encodings and its default bit-clock divider.
package opl3_pkg;

    typedef enum logic [1:0] {
        I2S_MODE_I2S = 2'd0,
        I2S_MODE_LJ  = 2'd1,
        I2S_MODE_RJ  = 2'd2,
        I2S_MODE_TDM = 2'd3
    } i2s_mode_t;

    typedef enum logic {
        I2S_TX_IDLE = 1'b0,
        I2S_TX_RUN  = 1'b1
    } i2s_tx_state_t;

    localparam int CLK_FREQ               = 49_152_000;
    localparam int ACTUAL_SAMPLE_FREQ     = 48_000;
    localparam int I2S_FRAME_BITS_DEFAULT = 64;

    // Number of clk cycles per SCLK half-period for a given sample rate and frame length.
    function automatic int i2s_clk_div_half(input int clk_freq, input int sample_freq,
                                            input int frame_bits);
        return clk_freq / (2 * sample_freq * frame_bits);
    endfunction

    localparam int I2S_CLK_DIV_HALF_DEFAULT =
        i2s_clk_div_half(CLK_FREQ, ACTUAL_SAMPLE_FREQ, I2S_FRAME_BITS_DEFAULT);

endpackage

// File: rtl/i2s_tx_multi_frame_fifo.sv
// Synchronous frame FIFO for the serial audio transmitter.
// Reads are first-word-fall-through, so the head frame is available in the same cycle it is popped.
module i2s_frame_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    count_reg;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count_reg == LW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign level   = count_reg;
    assign rd_data = mem[rd_ptr_reg];
    assign rd_en   = pop && !empty;
    // A write into a full FIFO is safe when the head leaves in the same cycle.
    assign wr_en   = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + LW'(1);
                2'b01:   count_reg <= count_reg - LW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx_multi.sv
// Multi-format serial audio transmitter (I2S / left-justified / right-justified / TDM).
// Acts as bus master: generates SCLK and WS and shifts out buffered frames of NUM_CHANNELS samples.
module i2s_tx_multi
    import opl3_pkg::*;
#(
    parameter int CLK_DIV_HALF = 4,
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int NUM_CHANNELS = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 enable,
    input  logic [1:0]                           mode,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] s_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
    output logic                                 underrun,
    output logic                                 i2s_sclk,
    output logic                                 i2s_ws,
    output logic                                 i2s_sd
);
    localparam int FRAME_W    = NUM_CHANNELS * SAMPLE_WIDTH;
    localparam int FRAME_BITS = NUM_CHANNELS * SLOT_WIDTH;
    localparam int PAD_BITS   = SLOT_WIDTH - SAMPLE_WIDTH;
    localparam int FIDX_W     = $clog2(FRAME_W);
    localparam int BCW        = $clog2(FRAME_BITS);
    localparam int DIV_W      = $clog2(CLK_DIV_HALF);
    localparam logic [BCW-1:0]   LAST_BIT = BCW'(FRAME_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_HALF - 1);

    i2s_tx_state_t      state_reg, state_next;
    i2s_mode_t          mode_reg, eff_mode;
    logic [DIV_W-1:0]   div_cnt_reg;
    logic [BCW-1:0]     bit_cnt_reg;
    logic               sclk_reg, ws_reg, sd_reg, underrun_reg, ready_en_reg;
    logic [FRAME_W-1:0] cur_frame_reg, prev_frame_reg, eff_frame, eff_prev;
    logic [FRAME_W-1:0] fifo_rd_data;
    logic               fifo_full, fifo_empty;
    logic               tc, fall, boundary, load, stop, push, pop;
    logic               sd_next, ws_next;
    int                 nb;

    assign s_ready  = ready_en_reg && !fifo_full;
    assign push     = s_valid && s_ready;
    assign tc       = (div_cnt_reg == DIV_LAST);
    assign fall     = (state_reg == I2S_TX_RUN) && tc && sclk_reg;
    assign boundary = fall && (bit_cnt_reg == LAST_BIT);
    assign load     = ((state_reg == I2S_TX_IDLE) && enable) || (boundary && enable);
    assign stop     = boundary && !enable;
    assign pop      = load && !fifo_empty;

    i2s_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (s_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Left-justified bit b of a frame; rj shifts the sample to the end of its slot.
    function automatic logic slot_bit(input logic [FRAME_W-1:0] f, input int b, input logic rj);
        int k, pos, idx;
        k   = b % SLOT_WIDTH;
        pos = rj ? (k - PAD_BITS) : k;
        idx = (b / SLOT_WIDTH) * SAMPLE_WIDTH + SAMPLE_WIDTH - 1 - pos;
        if (pos < 0 || pos >= SAMPLE_WIDTH) return 1'b0;
        return f[idx[FIDX_W-1:0]];
    endfunction

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            I2S_TX_IDLE: if (enable) state_next = I2S_TX_RUN;
            I2S_TX_RUN:  if (stop)   state_next = I2S_TX_IDLE;
            default:     state_next = I2S_TX_IDLE;
        endcase
    end

    // Next bit to present; at a frame load the freshly popped frame and mode take effect at bit 0.
    always_comb begin
        eff_mode  = mode_reg;
        eff_frame = cur_frame_reg;
        eff_prev  = prev_frame_reg;
        nb        = int'(bit_cnt_reg) + 1;
        if (load) begin
            eff_mode  = i2s_mode_t'(mode);
            eff_frame = fifo_empty ? '0 : fifo_rd_data;
            eff_prev  = cur_frame_reg;
            nb        = 0;
        end
        ws_next = (nb / SLOT_WIDTH) >= (NUM_CHANNELS / 2);
        sd_next = slot_bit(eff_frame, nb, 1'b0);
        case (eff_mode)
            I2S_MODE_I2S: sd_next = (nb == 0) ? slot_bit(eff_prev, FRAME_BITS - 1, 1'b0)
                                              : slot_bit(eff_frame, nb - 1, 1'b0);
            I2S_MODE_RJ:  sd_next = slot_bit(eff_frame, nb, 1'b1);
            I2S_MODE_TDM: ws_next = (nb == 0);
            default:      sd_next = slot_bit(eff_frame, nb, 1'b0);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= I2S_TX_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_en_reg   <= 1'b0;
            underrun_reg   <= 1'b0;
            div_cnt_reg    <= '0;
            sclk_reg       <= 1'b0;
            bit_cnt_reg    <= '0;
            sd_reg         <= 1'b0;
            ws_reg         <= 1'b0;
            mode_reg       <= I2S_MODE_I2S;
            cur_frame_reg  <= '0;
            prev_frame_reg <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            underrun_reg <= load && fifo_empty;
            if (state_reg == I2S_TX_RUN) begin
                div_cnt_reg <= tc ? '0 : div_cnt_reg + DIV_W'(1);
                if (tc) sclk_reg <= !sclk_reg;
            end else begin
                div_cnt_reg <= '0;
                sclk_reg    <= 1'b0;
            end
            if (stop) begin
                bit_cnt_reg <= '0;
                sd_reg      <= 1'b0;
                ws_reg      <= 1'b0;
            end else if (load || fall) begin
                bit_cnt_reg <= nb[BCW-1:0];
                sd_reg      <= sd_next;
                ws_reg      <= ws_next;
            end
            if (load) begin
                mode_reg       <= eff_mode;
                cur_frame_reg  <= eff_frame;
                prev_frame_reg <= eff_prev;
            end
        end
    end

    assign underrun = underrun_reg;
    assign i2s_sclk = sclk_reg;
    assign i2s_ws   = ws_reg;
    assign i2s_sd   = sd_reg;

endmodule

// File: tb/tb_i2s_tx_multi.sv
// Directed bench for i2s_tx_multi: a stereo instance for I2S/LJ/RJ/FIFO/underrun/enable tests
// and an 8-channel instance for TDM; serial output is decoded on SCLK rising edges.
module tb_i2s_tx_multi;
    import opl3_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // stereo instance
    logic        reset_n_a = 1'b0, enable_a = 1'b0, s_valid_a = 1'b0, s_ready_a;
    logic [1:0]  mode_a = 2'd0;
    logic [47:0] s_data_a = '0;
    logic [2:0]  level_a;
    logic        underrun_a, sclk_a, ws_a, sd_a;
    // eight-channel instance
    logic         reset_n_b = 1'b0, enable_b = 1'b0, s_valid_b = 1'b0, s_ready_b;
    logic [1:0]   mode_b = 2'd3;
    logic [191:0] s_data_b = '0;
    logic [2:0]   level_b;
    logic         underrun_b, sclk_b, ws_b, sd_b;

    i2s_tx_multi #(.CLK_DIV_HALF(2), .SAMPLE_WIDTH(24), .SLOT_WIDTH(32),
                   .NUM_CHANNELS(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset_n(reset_n_a), .enable(enable_a), .mode(mode_a),
        .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
        .fifo_level(level_a), .underrun(underrun_a),
        .i2s_sclk(sclk_a), .i2s_ws(ws_a), .i2s_sd(sd_a));

    i2s_tx_multi #(.CLK_DIV_HALF(2), .SAMPLE_WIDTH(24), .SLOT_WIDTH(32),
                   .NUM_CHANNELS(8), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset_n(reset_n_b), .enable(enable_b), .mode(mode_b),
        .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
        .fifo_level(level_b), .underrun(underrun_b),
        .i2s_sclk(sclk_b), .i2s_ws(ws_b), .i2s_sd(sd_b));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // capture serial bits at each SCLK rise
    logic cap_sd_a [512];
    logic cap_ws_a [512];
    logic cap_sd_b [512];
    logic cap_ws_b [512];
    int   cap_a = 0, ur_a = 0, cap_b = 0, ur_b = 0;
    logic prev_sclk_a = 1'b0, prev_sclk_b = 1'b0;

    always @(negedge clk) begin
        if (!reset_n_a) begin
            cap_a = 0; ur_a = 0; prev_sclk_a = 1'b0;
        end else begin
            if (sclk_a && !prev_sclk_a && cap_a < 512) begin
                cap_sd_a[cap_a] = sd_a; cap_ws_a[cap_a] = ws_a; cap_a++;
            end
            prev_sclk_a = sclk_a;
            if (underrun_a) ur_a++;
        end
    end

    always @(negedge clk) begin
        if (!reset_n_b) begin
            cap_b = 0; ur_b = 0; prev_sclk_b = 1'b0;
        end else begin
            if (sclk_b && !prev_sclk_b && cap_b < 512) begin
                cap_sd_b[cap_b] = sd_b; cap_ws_b[cap_b] = ws_b; cap_b++;
            end
            prev_sclk_b = sclk_b;
            if (underrun_b) ur_b++;
        end
    end

    function automatic logic [23:0] word_a(input int start);
        logic [23:0] w = '0;
        for (int i = 0; i < 24; i++) w = {w[22:0], cap_sd_a[start+i]};
        return w;
    endfunction

    function automatic logic [23:0] word_b(input int start);
        logic [23:0] w = '0;
        for (int i = 0; i < 24; i++) w = {w[22:0], cap_sd_b[start+i]};
        return w;
    endfunction

    function automatic logic or_a(input int from, input int to);
        logic r = 1'b0;
        for (int i = from; i <= to; i++) r |= cap_sd_a[i];
        return r;
    endfunction

    function automatic logic [63:0] ws_word_a(input int frame);
        logic [63:0] w = '0;
        for (int b = 0; b < 64; b++) w[63-b] = cap_ws_a[frame*64+b];
        return w;
    endfunction

    function automatic int ws_count_b(input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) n += int'(cap_ws_b[i]);
        return n;
    endfunction

    task automatic reset_a();
        @(negedge clk);
        reset_n_a = 1'b0; enable_a = 1'b0; s_valid_a = 1'b0;
        repeat (3) @(negedge clk);
        reset_n_a = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_a(input logic [47:0] d);
        int t = 0;
        logic ok = 1'b0;
        @(negedge clk);
        s_valid_a = 1'b1; s_data_a = d;
        while (!ok && t < 5000) begin
            if (s_ready_a) ok = 1'b1;
            @(negedge clk);
            t++;
        end
        s_valid_a = 1'b0;
        $display("push stereo frame 0x%012h accepted=%0d", d, ok);
        check("push_a", ok, 1'b1);
    endtask

    task automatic wait_cap_a(input int n);
        int t = 0;
        while (cap_a < n && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("wait_bits_a", cap_a >= n, 1'b1);
    endtask

    task automatic stop_a(input int total);
        wait_cap_a(total);
        repeat (12) @(negedge clk);
        check("stop_bits_a", 64'(cap_a), 64'(total));
        check("idle_outs_a", {sclk_a, ws_a, sd_a}, 3'b000);
    endtask

    logic [23:0] fl [5] = '{24'h123456, 24'h234567, 24'h345678, 24'h456789, 24'h56789A};
    logic [23:0] fr [5] = '{24'hFEDCBA, 24'hEDCBA9, 24'hDCBA98, 24'hCBA987, 24'hBA9876};
    logic [23:0] tdm_exp [8] = '{24'h000000, 24'h111111, 24'h222222, 24'h333333,
                                 24'h444444, 24'h555555, 24'h666666, 24'h777777};
    logic [47:0] frm = {24'h800001, 24'hA50FC3};

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_outs", {s_ready_a, sclk_a, ws_a, sd_a, underrun_a, level_a}, 0);
        reset_n_a = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", s_ready_a, 1'b1);

        // I2S stereo
        mode_a = I2S_MODE_I2S;
        push_a(frm);
        check("i2s_lvl1", level_a, 3'd1);
        enable_a = 1'b1;
        wait_cap_a(70);
        enable_a = 1'b0;
        stop_a(128);
        check("i2s_L", word_a(1), 24'hA50FC3);
        check("i2s_R", word_a(33), 24'h800001);
        check("i2s_ws", ws_word_a(0), 64'h00000000_FFFFFFFF);
        check("i2s_ws_fall", {cap_ws_a[63], cap_ws_a[64]}, 2'b10);
        check("i2s_pad", {or_a(25, 32), or_a(57, 64)}, 2'b00);
        check("i2s_ur", 64'(ur_a), 64'd1);
        check("i2s_ur_zero", or_a(65, 127), 1'b0);
        check("i2s_lvl0", level_a, 3'd0);

        // LJ
        reset_a();
        mode_a = I2S_MODE_LJ;
        push_a(frm);
        enable_a = 1'b1;
        wait_cap_a(70);
        enable_a = 1'b0;
        stop_a(128);
        check("lj_L", word_a(0), 24'hA50FC3);
        check("lj_R", word_a(32), 24'h800001);
        check("lj_pad", {or_a(24, 31), or_a(56, 63)}, 2'b00);
        check("lj_ws", ws_word_a(0), 64'h00000000_FFFFFFFF);

        // RJ
        reset_a();
        mode_a = I2S_MODE_RJ;
        push_a(frm);
        enable_a = 1'b1;
        wait_cap_a(70);
        enable_a = 1'b0;
        stop_a(128);
        check("rj_L", word_a(8), 24'hA50FC3);
        check("rj_R", word_a(40), 24'h800001);
        check("rj_pad", {or_a(0, 7), or_a(32, 39)}, 2'b00);
        check("rj_ws", ws_word_a(0), 64'h00000000_FFFFFFFF);

        // TDM, 8 channels
        @(negedge clk);
        reset_n_b = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 8; n++) s_data_b[n*24 +: 24] = tdm_exp[n];
        s_valid_b = 1'b1;
        begin
            int t = 0;
            logic ok = 1'b0;
            while (!ok && t < 100) begin
                if (s_ready_b) ok = 1'b1;
                @(negedge clk);
                t++;
            end
            s_valid_b = 1'b0;
            $display("push tdm frame accepted=%0d", ok);
            check("push_b", ok, 1'b1);
        end
        check("tdm_lvl1", level_b, 3'd1);
        enable_b = 1'b1;
        begin
            int t = 0;
            while (cap_b < 261 && t < 20000) begin @(negedge clk); t++; end
            enable_b = 1'b0;
            t = 0;
            while (cap_b < 512 && t < 20000) begin @(negedge clk); t++; end
            repeat (12) @(negedge clk);
        end
        check("tdm_bits", 64'(cap_b), 64'd512);
        check("tdm_ws_f0", {cap_ws_b[0], 8'(ws_count_b(0, 255))}, {1'b1, 8'd1});
        check("tdm_ws_f1", {cap_ws_b[256], 8'(ws_count_b(256, 511))}, {1'b1, 8'd1});
        for (int n = 0; n < 8; n++) check($sformatf("tdm_slot%0d", n), word_b(n*32), tdm_exp[n]);
        check("tdm_ur", 64'(ur_b), 64'd1);

        // FIFO fill and ordering
        reset_a();
        mode_a = I2S_MODE_LJ;
        for (int i = 0; i < 4; i++) push_a({fr[i], fl[i]});
        check("fifo_full_lvl", level_a, 3'd4);
        check("fifo_full_rdy", s_ready_a, 1'b0);
        enable_a = 1'b1;
        push_a({fr[4], fl[4]});
        check("fifo_refill_lvl", level_a, 3'd4);
        wait_cap_a(4*64 + 5);
        enable_a = 1'b0;
        stop_a(320);
        for (int f = 0; f < 5; f++) begin
            check($sformatf("fifo_L%0d", f), word_a(f*64), fl[f]);
            check($sformatf("fifo_R%0d", f), word_a(f*64 + 32), fr[f]);
        end
        check("fifo_no_ur", 64'(ur_a), 64'd0);

        // underrun then recovery
        reset_a();
        mode_a = I2S_MODE_LJ;
        enable_a = 1'b1;
        wait_cap_a(3*64 + 4);
        check("ur_count4", 64'(ur_a), 64'd4);
        push_a(frm);
        wait_cap_a(4*64 + 4);
        enable_a = 1'b0;
        stop_a(320);
        check("ur_zero_sd", or_a(0, 255), 1'b0);
        check("ur_rec_L", word_a(256), 24'hA50FC3);
        check("ur_rec_R", word_a(288), 24'h800001);
        check("ur_count_end", 64'(ur_a), 64'd4);

        // enable drop mid-frame, mode change mid-frame
        reset_a();
        mode_a = I2S_MODE_LJ;
        push_a(frm);
        enable_a = 1'b1;
        wait_cap_a(10);
        enable_a = 1'b0;
        wait_cap_a(20);
        mode_a = I2S_MODE_RJ;
        stop_a(64);
        check("drop_L_old_mode", word_a(0), 24'hA50FC3);
        check("drop_R_old_mode", word_a(32), 24'h800001);
        check("drop_pad", or_a(24, 31), 1'b0);
        begin
            int highs = 0;
            for (int i = 0; i < 20; i++) begin @(negedge clk); highs += int'(sclk_a); end
            check("idle_sclk_low", 64'(highs), 64'd0);
        end

        // restart in new mode, then reset mid-frame
        push_a(frm);
        push_a({fr[0], fl[0]});
        enable_a = 1'b1;
        wait_cap_a(64 + 40);
        check("restart_rj_L", word_a(64 + 8), 24'hA50FC3);
        check("pre_rst_state", {ws_a, level_a}, {1'b1, 3'd1});
        reset_n_a = 1'b0;
        @(negedge clk);
        check("mid_rst_outs", {s_ready_a, sclk_a, ws_a, sd_a, underrun_a, level_a}, 0);
        enable_a = 1'b0;
        reset_n_a = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
